midi_uart_rx: RTL and testbench
===============================

MIDI_UART_RX -- requirements
Module: midi_uart_rx

Interface
REQ-001 SHALL have parameter BAUD_CNT, default 3200, giving clk ticks per MIDI bit (31250 baud at 100 MHz).
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port midi_rx  input  1  raw serial MIDI line, idle high, asynchronous to clk.
REQ-005 SHALL have port status  output  8  status byte of the last completed message.
REQ-006 SHALL have port data1  output  8  first data byte of that message; 0 if none.
REQ-007 SHALL have port data2  output  8  second data byte of that message; 0 if none.
REQ-008 SHALL have port bytes_cnt  output  2  byte count of that message, 2 or 3.
REQ-009 SHALL have port msg_valid  output  1  single-cycle pulse when status/data1/data2/bytes_cnt update.
REQ-010 SHALL have port frame_err  output  1  single-cycle pulse when a byte has a low stop bit.

Function
REQ-011 SHALL pass midi_rx through a 2-flop synchronizer before any use.
REQ-012 SHALL use a byte FSM with states IDLE, START, DATA, STOP.
REQ-013 IDLE->START on a synchronized high-to-low transition; counter cleared.
REQ-014 START: at BAUD_CNT/2 ticks, line low -> DATA with counter cleared; line high -> IDLE (glitch, no output).
REQ-015 DATA: sample every BAUD_CNT ticks, 8 bits LSB first into a shift register -> STOP after bit 7.
REQ-016 STOP: sample after BAUD_CNT ticks; high -> byte accepted, back to IDLE; low -> frame_err pulse, byte dropped, parser state cleared, back to IDLE only after the line reads high.
REQ-017 The parser SHALL see accepted bytes one cycle after the stop sample.
REQ-018 Byte 0x80-0xEF SHALL load the status register and set the expected data count: 0x8n/0x9n/0xAn/0xBn/0xEn -> 2; 0xCn/0xDn -> 1; data index cleared.
REQ-019 Byte 0xF8-0xFF (realtime) SHALL be ignored with no change to parser state, including mid-message.
REQ-020 Byte 0xF0 SHALL enter sysex-discard; all bytes up to and including 0xF7 are ignored, except realtime bytes per REQ-019 and status bytes per REQ-018, which end discard.
REQ-021 Bytes 0xF1-0xF6 SHALL clear the running status; 0xF7 outside sysex is ignored.
REQ-022 A data byte (bit7=0) with no valid status SHALL be ignored.
REQ-023 When the last expected data byte arrives, the outputs SHALL update and msg_valid pulses in the same cycle; bytes_cnt = expected count + 1; data2 = 0 for 1-data messages.
REQ-024 Outputs SHALL hold until the next msg_valid; msg_valid never exceeds one cycle.
REQ-025 Counter width SHALL be $clog2(BAUD_CNT)+1 bits; no wrap occurs before the compare.

Reset
REQ-026 While rst is low: FSM in IDLE, synchronizer flops = 1, counters 0, status/data1/data2 = 0, bytes_cnt = 0, msg_valid = 0, frame_err = 0, running status invalid, sysex-discard cleared.
REQ-027 Reset asserted mid-byte SHALL abandon the byte; after release the block waits for a new falling edge.

Configuration
REQ-028 Macro MIDI_RUNNING_STATUS_EN defined: after a complete message the status stays valid and further data bytes form new messages with the same status.
REQ-029 Macro absent: the status is invalidated after every completed message; following data bytes are ignored per REQ-022.

Verification
REQ-030 Send 0x90,0x3C,0x64 -> one msg_valid; status=0x90, data1=0x3C, data2=0x64, bytes_cnt=3.
REQ-031 Send 0xC0,0x42 -> msg_valid; status=0xC0, data1=0x42, data2=0x00, bytes_cnt=2.
REQ-032 Send 0xB0,0x2E,0x7F,0x2F,0x00 -> with MIDI_RUNNING_STATUS_EN: two pulses, the second with data1=0x2F, data2=0x00; without it: one pulse only.
REQ-033 Send 0x90,0x3C,0xF8,0x64 -> one pulse, data1=0x3C, data2=0x64; 0xF8 has no effect.
REQ-034 Byte 0x90 sent with its stop bit forced low -> frame_err pulse, no msg_valid; the next 0x80,0x40,0x00 decodes normally.
REQ-035 A 0.5 us low glitch on idle midi_rx -> no byte, no pulses; rst pulsed low during data bit 3 -> all outputs 0, then the next full message decodes correctly.

Source files
------------

// File: rtl/midi_uart_rx.sv
// MIDI serial receiver and channel-message parser; optional MIDI_RUNNING_STATUS_EN macro.
// Ports: clk, rst (async active-low), midi_rx in; status/data1/data2/bytes_cnt, msg_valid, frame_err out.
module midi_uart_rx #(
    parameter int BAUD_CNT = 3200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       midi_rx,
    output logic [7:0] status,
    output logic [7:0] data1,
    output logic [7:0] data2,
    output logic [1:0] bytes_cnt,
    output logic       msg_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(BAUD_CNT) + 1;
    localparam logic [CW-1:0] HALF = CW'(BAUD_CNT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_CNT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_nx;
    logic        rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]  bit_idx, bit_idx_nx;
    logic [7:0]  shreg, shreg_nx;
    logic        stop_hold, stop_hold_nx;
    logic        byte_vld, byte_vld_nx;
    logic        fe_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            stop_hold <= 1'b0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_s1     <= midi_rx;
            rx_s2     <= rx_s1;
            rx_prev   <= rx_s2;
            state     <= state_nx;
            cnt       <= cnt_nx;
            bit_idx   <= bit_idx_nx;
            shreg     <= shreg_nx;
            stop_hold <= stop_hold_nx;
            byte_vld  <= byte_vld_nx;
            frame_err <= fe_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt + ONE;
        bit_idx_nx   = bit_idx;
        shreg_nx     = shreg;
        stop_hold_nx = stop_hold;
        byte_vld_nx  = 1'b0;
        fe_nx        = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (rx_prev && !rx_s2) state_nx = START;
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_nx     = '0;
                    bit_idx_nx = '0;
                    state_nx   = rx_s2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL) begin
                    cnt_nx     = '0;
                    shreg_nx   = {rx_s2, shreg[7:1]};
                    bit_idx_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nx = STOP;
                end
            end
            STOP: begin
                // After a bad stop bit, park here until the line recovers
                if (stop_hold) begin
                    cnt_nx = '0;
                    if (rx_s2) begin
                        stop_hold_nx = 1'b0;
                        state_nx     = IDLE;
                    end
                end else if (cnt == FULL) begin
                    cnt_nx = '0;
                    if (rx_s2) begin
                        byte_vld_nx = 1'b1;
                        state_nx    = IDLE;
                    end else begin
                        fe_nx        = 1'b1;
                        stop_hold_nx = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    logic       run_vld;
    logic [7:0] st_r;
    logic       need2;
    logic       idx;
    logic [7:0] d1_r;
    logic       sysex;

    logic is_rt, is_st, is_f0, is_f7, is_sys, is_data;
    logic c_rt, c_st, c_sx, c_f0, c_sys, c_dat;

    assign is_rt   = &shreg[7:3];
    assign is_st   = shreg[7] && (shreg[7:4] != 4'hF);
    assign is_f0   = (shreg == 8'hF0);
    assign is_f7   = (shreg == 8'hF7);
    assign is_sys  = (shreg[7:3] == 5'b11110);
    assign is_data = !shreg[7];

    // Mutually exclusive byte classes, in priority order
    assign c_rt  = is_rt;
    assign c_st  = is_st;
    assign c_sx  = sysex && !is_rt && !is_st;
    assign c_f0  = !sysex && is_f0;
    assign c_sys = !sysex && is_sys && !is_f0;
    assign c_dat = !sysex && is_data && run_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_vld   <= 1'b0;
            st_r      <= '0;
            need2     <= 1'b0;
            idx       <= 1'b0;
            d1_r      <= '0;
            sysex     <= 1'b0;
            status    <= '0;
            data1     <= '0;
            data2     <= '0;
            bytes_cnt <= '0;
            msg_valid <= 1'b0;
        end else begin
            msg_valid <= 1'b0;
            if (frame_err) begin
                run_vld <= 1'b0;
                idx     <= 1'b0;
                sysex   <= 1'b0;
            end else if (byte_vld) begin
                unique case (1'b1)
                    c_rt: ;
                    c_st: begin
                        st_r    <= shreg;
                        run_vld <= 1'b1;
                        need2   <= (shreg[7:5] != 3'b110);
                        idx     <= 1'b0;
                        sysex   <= 1'b0;
                    end
                    c_sx: begin
                        if (is_f7) sysex <= 1'b0;
                    end
                    c_f0: begin
                        sysex   <= 1'b1;
                        run_vld <= 1'b0;
                        idx     <= 1'b0;
                    end
                    c_sys: begin
                        if (!is_f7) begin
                            run_vld <= 1'b0;
                            idx     <= 1'b0;
                        end
                    end
                    c_dat: begin
                        if (!idx && need2) begin
                            d1_r <= shreg;
                            idx  <= 1'b1;
                        end else begin
                            status    <= st_r;
                            data1     <= idx ? d1_r : shreg;
                            data2     <= idx ? shreg : 8'h00;
                            bytes_cnt <= idx ? 2'd3 : 2'd2;
                            msg_valid <= 1'b1;
                            idx       <= 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
                            run_vld   <= 1'b1;
`else
                            run_vld   <= 1'b0;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_midi_uart_rx.sv
// Randomized scoreboard bench for midi_uart_rx.
// A byte-level reference model queues expected messages; a monitor checks them.
`timescale 1ns/1ps
module tb_midi_uart_rx;

    localparam int BAUD = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       midi_rx = 1'b1;
    logic [7:0] status, data1, data2;
    logic [1:0] bytes_cnt;
    logic       msg_valid, frame_err;

    always #5 clk = ~clk;

    midi_uart_rx #(.BAUD_CNT(BAUD)) dut (
        .clk(clk),
        .rst(rst),
        .midi_rx(midi_rx),
        .status(status),
        .data1(data1),
        .data2(data2),
        .bytes_cnt(bytes_cnt),
        .msg_valid(msg_valid),
        .frame_err(frame_err)
    );

    typedef struct packed {
        logic [7:0] st;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [1:0] n;
    } msg_t;

    int   vectors = 0;
    int   miscompares = 0;
    msg_t exp_q[$];
    int   ferr_exp = 0;

    bit         m_have = 0;
    logic [7:0] m_st = 8'h00;
    int         m_need = 2;
    logic [7:0] m_dq[$];
    bit         m_sx = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic void model_clear();
        m_have = 0;
        m_dq.delete();
        m_sx = 0;
    endfunction

    function automatic void model_byte(logic [7:0] b);
        msg_t m;
        if (b >= 8'hF8) return;
        if (b >= 8'h80 && b <= 8'hEF) begin
            m_st   = b;
            m_have = 1;
            m_need = ((b >> 4) == 8'hC || (b >> 4) == 8'hD) ? 1 : 2;
            m_dq.delete();
            m_sx = 0;
            return;
        end
        if (m_sx) begin
            if (b == 8'hF7) m_sx = 0;
            return;
        end
        if (b == 8'hF0) begin
            m_sx = 1;
            m_have = 0;
            m_dq.delete();
            return;
        end
        if (b >= 8'hF1) begin
            if (b != 8'hF7) begin
                m_have = 0;
                m_dq.delete();
            end
            return;
        end
        if (!m_have) return;
        m_dq.push_back(b);
        if (m_dq.size() == m_need) begin
            m.st = m_st;
            m.d1 = m_dq[0];
            m.d2 = (m_need == 2) ? m_dq[1] : 8'h00;
            m.n  = 2'(m_need + 1);
            exp_q.push_back(m);
            m_dq.delete();
`ifndef MIDI_RUNNING_STATUS_EN
            m_have = 0;
`endif
        end
    endfunction

    task automatic send_byte(logic [7:0] b, bit bad_stop = 0);
        if (bad_stop) begin
            ferr_exp++;
            model_clear();
        end else begin
            model_byte(b);
        end
        midi_rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            midi_rx = b[i];
            repeat (BAUD) @(negedge clk);
        end
        midi_rx = !bad_stop;
        repeat (BAUD) @(negedge clk);
        midi_rx = 1'b1;
        repeat ($urandom_range(2, 40)) @(negedge clk);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_status"}, {24'h0, status}, 32'h0);
        check({tag, "_data1"}, {24'h0, data1}, 32'h0);
        check({tag, "_data2"}, {24'h0, data2}, 32'h0);
        check({tag, "_bytes_cnt"}, {30'h0, bytes_cnt}, 32'h0);
        check({tag, "_msg_valid"}, {31'h0, msg_valid}, 32'h0);
        check({tag, "_frame_err"}, {31'h0, frame_err}, 32'h0);
    endtask

    bit mv_prev = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (msg_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_msg got %h %h %h %0d want none",
                             status, data1, data2, bytes_cnt);
                end else begin
                    msg_t e;
                    e = exp_q.pop_front();
                    if ({status, data1, data2, bytes_cnt} !== e) begin
                        miscompares++;
                        $display("FAIL msg got %h %h %h %0d want %h %h %h %0d",
                                 status, data1, data2, bytes_cnt,
                                 e.st, e.d1, e.d2, e.n);
                    end
                end
                if (mv_prev) begin
                    miscompares++;
                    $display("FAIL msg_valid_width got 2+ cycles want 1");
                end
            end
            if (frame_err) begin
                vectors++;
                if (ferr_exp == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_frame_err got 1 want 0");
                end else begin
                    ferr_exp--;
                end
            end
        end
        mv_prev = msg_valid;
    end

    logic [7:0] rb;
    int         r;
    logic [7:0] pb;

    initial begin
        repeat (5) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // Note on, program change, running-status sequence, realtime insert
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        send_byte(8'hC0); send_byte(8'h42);
        send_byte(8'hB0); send_byte(8'h2E); send_byte(8'h7F);
        send_byte(8'h2F); send_byte(8'h00);
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF8);
        send_byte(8'h64);

        // Bad stop bit, then a clean message
        send_byte(8'h90, 1);
        send_byte(8'h80); send_byte(8'h40); send_byte(8'h00);

        // Short low glitch on an idle line
        midi_rx = 1'b0;
        repeat (BAUD / 4) @(negedge clk);
        midi_rx = 1'b1;
        repeat (BAUD * 12) @(negedge clk);

        // Reset during data bit 3 of the last byte of a note
        send_byte(8'h90); send_byte(8'h3C);
        pb = 8'h64;
        midi_rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            midi_rx = pb[i];
            repeat (BAUD) @(negedge clk);
        end
        midi_rx = pb[3];
        repeat (BAUD / 2) @(negedge clk);
        rst = 1'b0;
        midi_rx = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        check_zero("midreset");
        rst = 1'b1;
        repeat (10) @(negedge clk);
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);

        // Randomized byte stream
        for (int k = 0; k < 100; k++) begin
            r = $urandom_range(0, 99);
            if (r < 35)      rb = 8'($urandom_range(8'h00, 8'h7F));
            else if (r < 55) rb = 8'($urandom_range(8'h80, 8'hEF));
            else if (r < 65) rb = 8'($urandom_range(8'hF8, 8'hFF));
            else if (r < 70) rb = 8'hF0;
            else if (r < 75) rb = 8'hF7;
            else if (r < 78) rb = 8'($urandom_range(8'hF1, 8'hF6));
            else             rb = 8'($urandom_range(8'h00, 8'h7F));
            if (r >= 78 && r < 81) send_byte(8'($urandom), 1);
            else send_byte(rb);
        end

        repeat (200) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 32'd0);
        check("ferr_pending", ferr_exp, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
